// File: rtl/rggen_rtl_pkg.sv
// Shared access/status encodings for the register interface, plus the
// selector's sequencing states.
package rggen_rtl_pkg;

  localparam int RGGEN_ACCESS_DATA_BIT = 0;

  typedef enum logic [1:0] {
    RGGEN_READ         = 2'b00,
    RGGEN_POSTED_WRITE = 2'b01,
    RGGEN_WRITE        = 2'b11
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    SEL_IDLE,
    SEL_DECODE,
    SEL_ACCESS,
    SEL_RESPONSE
  } rggen_selector_state;

endpackage

// File: rtl/rggen_register_selector_if.sv
// Request/response bundle between the bus bridge (master) and the selector
// (slave); register-side select/ready travel with it.
interface rggen_register_selector_if
  import rggen_rtl_pkg::*;
#(
  parameter int WINDOWS = 4,
  parameter int WIDTH   = 8
);
  logic                 i_request_valid;
  logic                 o_request_ready;
  logic [WIDTH-1:0]     i_address;
  rggen_access          i_access;
  logic [WINDOWS-1:0]   i_additional_match;
  logic [WINDOWS-1:0]   o_select;
  rggen_access          o_access;
  logic [WINDOWS-1:0]   i_register_ready;
  logic                 o_response_valid;
  logic                 i_response_ready;
  rggen_status          o_response_status;

  modport master (
    output i_request_valid, i_address, i_access, i_additional_match,
           i_register_ready, i_response_ready,
    input  o_request_ready, o_select, o_access, o_response_valid,
           o_response_status
  );

  modport slave (
    input  i_request_valid, i_address, i_access, i_additional_match,
           i_register_ready, i_response_ready,
    output o_request_ready, o_select, o_access, o_response_valid,
           o_response_status
  );
endinterface

// File: rtl/rggen_address_window_matcher.sv
// Combinational range/permission check of one address window.
module rggen_address_window_matcher #(
  parameter int             WIDTH         = 8,
  parameter int             LSB           = 0,
  parameter bit [WIDTH-1:0] START_ADDRESS = '0,
  parameter bit [WIDTH-1:0] END_ADDRESS   = '0,
  parameter bit             READABLE      = 1'b1,
  parameter bit             WRITABLE      = 1'b1
)(
  input  logic [WIDTH-1:0] i_address,
  input  logic             i_write,
  input  logic             i_additional_match,
  output logic             o_address_hit,
  output logic             o_access_ok
);
  localparam bit [WIDTH-LSB-1:0] START = START_ADDRESS[WIDTH-1:LSB];
  localparam bit [WIDTH-LSB-1:0] END   = END_ADDRESS[WIDTH-1:LSB];

  logic [WIDTH-LSB-1:0] addr;
  logic                 lower_ok;
  logic                 upper_ok;

  assign addr = i_address[WIDTH-1:LSB];

  // Open-ended bounds are tied off so no always-true compare is built.
  if (START == '0) begin : g_lower_open
    assign lower_ok = 1'b1;
  end else begin : g_lower
    assign lower_ok = addr >= START;
  end

  if (END == '1) begin : g_upper_open
    assign upper_ok = 1'b1;
  end else begin : g_upper
    assign upper_ok = addr <= END;
  end

  assign o_address_hit = i_additional_match && lower_ok && upper_ok;
  assign o_access_ok   = i_write ? WRITABLE : READABLE;
endmodule

// File: rtl/rggen_register_selector.sv
// Registered multi-window selector: captures one access, decodes it with
// lowest-index priority, selects the hit window and returns a status.
module rggen_register_selector
  import rggen_rtl_pkg::*;
#(
  parameter int                             WINDOWS       = 4,
  parameter int                             WIDTH         = 8,
  parameter int                             LSB           = 0,
  parameter bit [WINDOWS-1:0][WIDTH-1:0]    START_ADDRESS = '0,
  parameter bit [WINDOWS-1:0][WIDTH-1:0]    END_ADDRESS   = '0,
  parameter bit [WINDOWS-1:0]               READABLE      = '1,
  parameter bit [WINDOWS-1:0]               WRITABLE      = '1,
  parameter int                             TIMEOUT       = 0
)(
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  rggen_register_selector_if.slave  bus
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  rggen_selector_state state_q, state_d;
  logic [WIDTH-1:0]    address_q, address_d;
  rggen_access         access_q, access_d;
  logic [WINDOWS-1:0]  match_q, match_d;
  logic [WINDOWS-1:0]  select_q, select_d;
  rggen_status         status_q, status_d;
  logic [CW-1:0]       count_q, count_d;

  logic [WINDOWS-1:0]  address_hit;
  logic [WINDOWS-1:0]  access_ok;
  logic [WINDOWS-1:0]  winner;
  logic                register_done;
  logic                timed_out;

  for (genvar g = 0; g < WINDOWS; g++) begin : g_window
    rggen_address_window_matcher #(
      .WIDTH         (WIDTH),
      .LSB           (LSB),
      .START_ADDRESS (START_ADDRESS[g]),
      .END_ADDRESS   (END_ADDRESS[g]),
      .READABLE      (READABLE[g]),
      .WRITABLE      (WRITABLE[g])
    ) u_matcher (
      .i_address          (address_q),
      .i_write            (access_q[RGGEN_ACCESS_DATA_BIT]),
      .i_additional_match (match_q[g]),
      .o_address_hit      (address_hit[g]),
      .o_access_ok        (access_ok[g])
    );
  end

  // Isolate the lowest set hit bit: overlaps resolve to the lower index.
  assign winner        = address_hit & (~address_hit + WINDOWS'(1));
  assign register_done = |(bus.i_register_ready & select_q);
  assign timed_out     = (TIMEOUT > 0) && (count_q == CW'(TIMEOUT));

  always_comb begin
    state_d   = state_q;
    address_d = address_q;
    access_d  = access_q;
    match_d   = match_q;
    select_d  = select_q;
    status_d  = status_q;
    count_d   = count_q;
    case (state_q)
      SEL_IDLE: begin
        if (bus.i_request_valid) begin
          address_d = bus.i_address;
          access_d  = bus.i_access;
          match_d   = bus.i_additional_match;
          state_d   = SEL_DECODE;
        end
      end
      SEL_DECODE: begin
        if (winner == '0) begin
          status_d = RGGEN_DECODE_ERROR;
          state_d  = SEL_RESPONSE;
        end else if ((winner & access_ok) == '0) begin
          status_d = RGGEN_SLAVE_ERROR;
          state_d  = SEL_RESPONSE;
        end else begin
          select_d = winner;
          count_d  = '0;
          state_d  = SEL_ACCESS;
        end
      end
      SEL_ACCESS: begin
        // Ready is checked first so a same-cycle timeout still completes OKAY.
        if (register_done) begin
          status_d = RGGEN_OKAY;
          select_d = '0;
          state_d  = SEL_RESPONSE;
        end else if (timed_out) begin
          status_d = RGGEN_SLAVE_ERROR;
          select_d = '0;
          state_d  = SEL_RESPONSE;
        end else if (count_q != CW'(TIMEOUT)) begin
          count_d = count_q + CW'(1);
        end
      end
      SEL_RESPONSE: begin
        if (bus.i_response_ready) begin
          state_d = SEL_IDLE;
        end
      end
      default: state_d = SEL_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= SEL_IDLE;
      address_q <= '0;
      access_q  <= RGGEN_READ;
      match_q   <= '0;
      select_q  <= '0;
      status_q  <= RGGEN_OKAY;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      address_q <= address_d;
      access_q  <= access_d;
      match_q   <= match_d;
      select_q  <= select_d;
      status_q  <= status_d;
      count_q   <= count_d;
    end
  end

  assign bus.o_request_ready   = (state_q == SEL_IDLE);
  assign bus.o_select          = select_q;
  assign bus.o_access          = access_q;
  assign bus.o_response_valid  = (state_q == SEL_RESPONSE);
  assign bus.o_response_status = status_q;
endmodule

// File: tb/tb_rggen_register_selector.sv
// Scoreboard bench for the register selector: stimulus pushes model
// predictions, a monitor pops them as responses appear.
module tb_rggen_register_selector;
  import rggen_rtl_pkg::*;

  localparam int W  = 4;
  localparam int AW = 8;
  localparam int TO = 3;
  localparam bit [W-1:0][AW-1:0] S  = {8'h20, 8'h30, 8'h10, 8'h20};
  localparam bit [W-1:0][AW-1:0] E  = {8'h27, 8'h3F, 8'h13, 8'h2F};
  localparam bit [W-1:0]         RD = 4'b1111;
  localparam bit [W-1:0]         WR = 4'b1011;

  typedef struct {
    logic [W-1:0] sel;
    rggen_status  st;
    rggen_access  acc;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0, cyc = 0, issued = 0, done = 0, lat_cfg = 0;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rggen_register_selector_if #(.WINDOWS(W), .WIDTH(AW)) bus();

  rggen_register_selector #(
    .WINDOWS(W), .WIDTH(AW), .LSB(0),
    .START_ADDRESS(S), .END_ADDRESS(E),
    .READABLE(RD), .WRITABLE(WR), .TIMEOUT(TO)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: first window (ascending) whose range covers the address and
  // whose qualifier is set decides; k = ACCESS cycle in which ready arrives.
  function automatic exp_t model(input logic [AW-1:0] a, input bit wr,
                                 input logic [W-1:0] m, input int k);
    exp_t e;
    e.sel = '0; e.st = RGGEN_DECODE_ERROR; e.lat = 1; e.acc_cyc = 0;
    e.acc = wr ? RGGEN_WRITE : RGGEN_READ;
    for (int i = 0; i < W; i++) begin
      if (m[i] && a >= S[i] && a <= E[i]) begin
        if (wr ? WR[i] : RD[i]) begin
          e.sel = W'(1) << i;
          e.st  = (k <= TO) ? RGGEN_OKAY : RGGEN_SLAVE_ERROR;
          e.lat = (k <= TO) ? k + 2 : TO + 2;
        end else begin
          e.st = RGGEN_SLAVE_ERROR;
        end
        return e;
      end
    end
    return e;
  endfunction

  // Register array: selected window answers after lat_cfg ACCESS cycles;
  // other windows toggle randomly and must be ignored.
  initial begin
    int acnt;
    acnt = 0;
    bus.i_register_ready = '0;
    forever begin
      @(negedge clk);
      if (bus.o_select != '0) begin
        bus.i_register_ready = (W'($urandom) & ~bus.o_select) |
                               ((acnt == lat_cfg) ? bus.o_select : '0);
        acnt++;
      end else begin
        acnt = 0;
        bus.i_register_ready = W'($urandom);
      end
    end
  end

  // Response monitor.
  initial begin
    logic [W-1:0] seen;
    bit           checked;
    int           rdly;
    exp_t         e;
    seen = '0; checked = 0; rdly = 0;
    e.sel = '0; e.st = RGGEN_OKAY; e.acc = RGGEN_READ; e.lat = 0; e.acc_cyc = 0;
    bus.i_response_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = '0; checked = 0; bus.i_response_ready = 1'b0;
      end else begin
        if (bus.o_select != '0) check("select_onehot", 32'($onehot(bus.o_select)), 32'd1);
        seen |= bus.o_select;
        if (bus.o_response_valid) begin
          if (!checked) begin
            if (sb.size() == 0) begin
              total++; bad++;
              $display("FAIL unexpected_response actual=%0h required=none", bus.o_response_status);
              e.st = bus.o_response_status;
            end else begin
              e = sb.pop_front();
              check("status",  32'(bus.o_response_status), 32'(e.st));
              check("select",  32'(seen), 32'(e.sel));
              check("access",  32'(bus.o_access), 32'(e.acc));
              check("latency", cyc - e.acc_cyc, e.lat);
              done++;
            end
            checked = 1;
            seen    = '0;
            rdly    = $urandom_range(0, 2);
          end else begin
            check("status_stable", 32'(bus.o_response_status), 32'(e.st));
          end
          if (rdly == 0) bus.i_response_ready = 1'b1;
          else begin bus.i_response_ready = 1'b0; rdly--; end
        end else begin
          checked = 0;
          bus.i_response_ready = 1'b0;
        end
      end
    end
  end

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (!bus.o_request_ready && guard < 50) begin @(negedge clk); guard++; end
    check("request_ready_wait", 32'(bus.o_request_ready), 32'd1);
  endtask

  task automatic issue(input logic [AW-1:0] a, input bit wr, input logic [W-1:0] m, input int k);
    exp_t e;
    int   guard;
    wait_ready();
    lat_cfg = k;
    bus.i_request_valid    = 1'b1;
    bus.i_address          = a;
    bus.i_access           = wr ? RGGEN_WRITE : RGGEN_READ;
    bus.i_additional_match = m;
    e = model(a, wr, m, k);
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
    issued++;
    @(negedge clk);
    bus.i_request_valid    = 1'b0;
    bus.i_address          = AW'($urandom);
    bus.i_additional_match = W'($urandom);
    guard = 0;
    while (done != issued && guard < 60) begin @(negedge clk); guard++; end
    check("response_arrived", done, issued);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [W-1:0]  m;
    bus.i_request_valid    = 1'b0;
    bus.i_address          = '0;
    bus.i_access           = RGGEN_READ;
    bus.i_additional_match = '0;
    repeat (2) @(negedge clk);
    check("rst_select",   32'(bus.o_select), 32'd0);
    check("rst_valid",    32'(bus.o_response_valid), 32'd0);
    check("rst_status",   32'(bus.o_response_status), 32'(RGGEN_OKAY));
    check("rst_access",   32'(bus.o_access), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.o_request_ready), 32'd1);

    issue(8'h12, 1'b0, 4'hF, 2);   // window1 OKAY
    issue(8'h40, 1'b0, 4'hF, 0);   // no window
    issue(8'h35, 1'b1, 4'hF, 0);   // window2 read-only
    issue(8'h11, 1'b0, 4'hF, 9);   // timeout
    issue(8'h10, 1'b0, 4'hF, TO);  // ready on timeout cycle
    issue(8'h13, 1'b1, 4'hF, 0);
    issue(8'h22, 1'b0, 4'hF, 1);   // overlap -> window0
    issue(8'h22, 1'b0, 4'hE, 1);   // window0 disqualified -> window3
    issue(8'h2A, 1'b0, 4'hE, 1);
    issue(8'h35, 1'b0, 4'hF, 0);

    // Reset in the middle of an ACCESS with no response pending.
    wait_ready();
    lat_cfg = 20;
    bus.i_request_valid    = 1'b1;
    bus.i_address          = 8'h12;
    bus.i_access           = RGGEN_WRITE;
    bus.i_additional_match = 4'hF;
    @(negedge clk);
    bus.i_request_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_select", 32'(bus.o_select), 32'h2);
    check("pre_rst_access", 32'(bus.o_access), 32'(RGGEN_WRITE));
    rst_n = 1'b0;
    #1;
    check("mid_rst_select", 32'(bus.o_select), 32'd0);
    check("mid_rst_valid",  32'(bus.o_response_valid), 32'd0);
    check("mid_rst_status", 32'(bus.o_response_status), 32'(RGGEN_OKAY));
    check("mid_rst_access", 32'(bus.o_access), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.o_request_ready), 32'd1);
    check("post_rst_valid", 32'(bus.o_response_valid), 32'd0);
    issue(8'h12, 1'b0, 4'hF, 0);

    for (int n = 0; n < 80; n++) begin
      a = AW'($urandom_range(8'h08, 8'h47));
      m = ($urandom_range(0, 3) == 0) ? W'($urandom) : 4'hF;
      issue(a, 1'($urandom), m, int'($urandom_range(0, 5)));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rggen_register_selector.md
# rggen_register_selector

Registered, multi-window address selector sitting between the host bus bridge and the register array. It accepts one access at a time, decodes its address against WINDOWS parametrised ranges with per-window access permissions, drives a one-hot select to the hit window and waits for that register's ready. It returns a status response (okay / slave error / decode error), with an optional timeout. It generalises single-window, combinational matching to N windows with a handshaked, stateful access sequence.

## Interface
- WINDOWS, 4: number of address windows (≥1)
- WIDTH, 8: address width
- LSB, 0: lowest address bit compared (byte-lane bits ignored)
- START_ADDRESS, '0: bit [WINDOWS-1:0][WIDTH-1:0], per-window inclusive start
- END_ADDRESS, '0: bit [WINDOWS-1:0][WIDTH-1:0], per-window inclusive end
- READABLE, '1: bit [WINDOWS-1:0], window accepts reads
- WRITABLE, '1: bit [WINDOWS-1:0], window accepts writes
- TIMEOUT, 0: cycles to wait for register ready; 0 disables timeout
- Clock/reset: one clock; reset is asynchronous and active-low.
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_request_valid  input  1  request present
- o_request_ready  output  1  selector idle, request accepted when valid&&ready
- i_address  input  WIDTH  request address
- i_access  input  rggen_access  request access type (bit RGGEN_ACCESS_DATA_BIT = write)
- i_additional_match  input  WINDOWS  per-window qualifier, sampled with the request
- o_select  output  WINDOWS  one-hot select to hit window
- o_access  output  rggen_access  registered access type
- i_register_ready  input  WINDOWS  per-window completion
- o_response_valid  output  1  response present
- i_response_ready  input  1  response consumed
- o_response_status  output  rggen_status  RGGEN_OKAY / RGGEN_SLAVE_ERROR / RGGEN_DECODE_ERROR

## Operation
- States: IDLE, DECODE, ACCESS, RESPONSE.
- IDLE: o_request_ready=1. On valid&&ready, register address, access, i_additional_match; go DECODE.
- DECODE: per window, address_hit = registered address[WIDTH-1:LSB] within [START, END] (equality if START==END over those bits) and additional_match bit; access_ok = READABLE for reads, WRITABLE for writes.
  - Lowest-index window with address_hit wins (overlaps resolved by priority).
  - No hit → RESPONSE, status DECODE_ERROR.
  - Hit but !access_ok → RESPONSE, status SLAVE_ERROR; o_select never asserted.
  - Hit and access_ok → ACCESS, latch winning index.
- ACCESS: o_select one-hot at winner. i_register_ready of winner → RESPONSE, OKAY. Ready of non-selected windows ignored. If TIMEOUT>0 and counter reaches TIMEOUT without ready → RESPONSE, SLAVE_ERROR. Ready and timeout in same cycle: ready wins (OKAY).
- RESPONSE: o_response_valid=1, status stable until i_response_ready; then IDLE.
- Counter width: $clog2(TIMEOUT+1); cleared on entry to ACCESS; saturates, never wraps.
- Reset (any state, asynchronous): state IDLE; o_request_ready=1 once released; o_select=0, o_response_valid=0, o_response_status=RGGEN_OKAY, o_access=0, counter=0. In-flight access is dropped, no response.

## Timing
- Accept at edge N; DECODE during N+1; o_select earliest asserted in cycle N+2.
- Error responses: o_response_valid in cycle N+2.
- OKAY: o_response_valid the cycle after winner's ready sampled high; ready sampled in first ACCESS cycle → response at N+3.
- Timeout: SLAVE_ERROR valid TIMEOUT+1 cycles after ACCESS entry.
- o_select deasserts the same edge RESPONSE is entered; new request accepted earliest the cycle after response handshake.
- All outputs registered or decoded from state only; no combinational path input→output except none.

## Structure
- rggen_rtl_pkg: rggen_access, RGGEN_ACCESS_DATA_BIT, rggen_status (existing); add rggen_selector_state enum.
- Sub-module rggen_address_window_matcher (one per window, generate loop): combinational address_hit/access_ok for one window with WIDTH, LSB, START/END, READABLE/WRITABLE.
- Top holds FSM, capture registers, priority encoder, timeout counter.

## Test plan
- WINDOWS=4, window1=[0x10,0x13], read 0x12, ready after 2 cycles → o_select=4'b0010 from N+2, OKAY response.
- Read 0x40 with no window covering → DECODE_ERROR at N+2, o_select stays 0.
- Write to window2 with WRITABLE[2]=0 → SLAVE_ERROR, o_select never asserted.
- TIMEOUT=3, ready held low → SLAVE_ERROR valid 4 cycles after ACCESS entry; ready asserted on timeout cycle → OKAY.
- Overlapping windows 0 and 3 both hit → window 0 selected; i_additional_match[0]=0 → window 3 selected.
- Assert i_rst_n low during ACCESS with i_response_ready low → all outputs reset values immediately, next request decoded normally.
